// File: rtl/config_stream_loader.sv
// config_stream_loader: streams host words LSB-first onto the fabric config chain.
// Optional CRC-16 trailer word check is enabled by defining CONFIG_LOADER_CRC_EN.
module config_stream_loader #(
  parameter int CHAIN_LENGTH = 1752,
  parameter int WORD_WIDTH   = 32,
  parameter int COUNT_WIDTH  = 11
) (
  input  logic                  config_clock,
  input  logic                  config_nreset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [WORD_WIDTH-1:0] word_data,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  chain_data,
  output logic                  chain_enable,
  output logic                  fabric_enable,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int WB_W = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
  localparam logic [COUNT_WIDTH-1:0] LAST_BIT = COUNT_WIDTH'(CHAIN_LENGTH - 1);
  localparam logic [WB_W-1:0] WORD_END = WB_W'(WORD_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

`ifdef CONFIG_LOADER_CRC_EN
  localparam state_t S_END = S_CHECK;
`else
  localparam state_t S_END = S_DONE;
`endif

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [WORD_WIDTH-1:0]   r_sreg;
  logic [WORD_WIDTH-1:0]   w_sreg_nxt;
  logic [COUNT_WIDTH-1:0]  r_bit_cnt;
  logic [COUNT_WIDTH-1:0]  w_bit_cnt_nxt;
  logic [WB_W-1:0]         r_word_bit;
  logic [WB_W-1:0]         w_word_bit_nxt;
  logic                    r_chain_data;
  logic                    w_chain_data_nxt;
  logic                    r_chain_enable;
  logic                    w_chain_enable_nxt;
  logic                    r_fabric_enable;
  logic                    w_fabric_enable_nxt;
  logic                    r_busy;
  logic                    w_busy_nxt;
  logic                    r_done;
  logic                    w_done_nxt;

  logic w_idle_like;
  logic w_start;
  logic w_accept;
  logic w_last_bit;
  logic w_word_end;

  assign word_ready  = (r_state == S_LOAD) || (r_state == S_CHECK);
  assign w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE) ||
                       (r_state == S_ERROR);
  assign w_start     = start && !abort && w_idle_like;
  assign w_accept    = word_valid && word_ready && !abort;
  assign w_last_bit  = (r_bit_cnt == LAST_BIT);
  assign w_word_end  = (r_word_bit == WORD_END);

`ifdef CONFIG_LOADER_CRC_EN
  logic [15:0] r_crc;
  logic        r_error;
  logic        w_fb;
  logic        w_crc_ok;

  assign w_fb     = r_crc[15] ^ r_sreg[0];
  assign w_crc_ok = (word_data[15:0] == r_crc);

  always_ff @(posedge config_clock or negedge config_nreset) begin
    if (!config_nreset) begin
      r_crc   <= 16'hFFFF;
      r_error <= 1'b0;
    end else begin
      if (w_start) begin
        r_crc <= 16'hFFFF;
      end else if (!abort && r_state == S_SHIFT) begin
        r_crc <= {r_crc[14:0], 1'b0} ^ (w_fb ? 16'h1021 : 16'h0000);
      end
      r_error <= !abort && !w_start && (r_state == S_ERROR);
    end
  end

  assign error = r_error;
`else
  assign error = 1'b0;
`endif

  always_ff @(posedge config_clock or negedge config_nreset) begin
    if (!config_nreset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) w_state_nxt = S_LOAD;
        end
        S_LOAD: begin
          if (w_accept) w_state_nxt = S_SHIFT;
        end
        S_SHIFT: begin
          // the tail of a partial last word is dropped here
          if (w_last_bit) w_state_nxt = S_END;
          else if (w_word_end) w_state_nxt = S_LOAD;
        end
        S_CHECK: begin
`ifdef CONFIG_LOADER_CRC_EN
          if (w_accept) w_state_nxt = w_crc_ok ? S_DONE : S_ERROR;
`else
          w_state_nxt = S_IDLE;
`endif
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_sreg_nxt          = r_sreg;
    w_bit_cnt_nxt       = r_bit_cnt;
    w_word_bit_nxt      = r_word_bit;
    w_chain_data_nxt    = r_chain_data;
    w_chain_enable_nxt  = 1'b0;
    w_fabric_enable_nxt = 1'b0;
    w_busy_nxt          = 1'b0;
    w_done_nxt          = 1'b0;
    if (!abort) begin
      if (w_start) begin
        w_busy_nxt     = 1'b1;
        w_bit_cnt_nxt  = '0;
        w_word_bit_nxt = '0;
      end else begin
        unique case (r_state)
          S_LOAD: begin
            w_busy_nxt = 1'b1;
            if (w_accept) begin
              w_sreg_nxt     = word_data;
              w_word_bit_nxt = '0;
            end
          end
          S_SHIFT: begin
            w_busy_nxt         = 1'b1;
            w_chain_enable_nxt = 1'b1;
            w_chain_data_nxt   = r_sreg[0];
            w_sreg_nxt         = r_sreg >> 1;
            w_bit_cnt_nxt      = r_bit_cnt + COUNT_WIDTH'(1);
            w_word_bit_nxt     = r_word_bit + WB_W'(1);
          end
          S_CHECK: begin
            w_busy_nxt = 1'b1;
          end
          S_DONE: begin
            w_done_nxt          = 1'b1;
            w_fabric_enable_nxt = 1'b1;
          end
          default: begin
          end
        endcase
      end
    end
  end

  always_ff @(posedge config_clock or negedge config_nreset) begin
    if (!config_nreset) begin
      r_sreg          <= '0;
      r_bit_cnt       <= '0;
      r_word_bit      <= '0;
      r_chain_data    <= 1'b0;
      r_chain_enable  <= 1'b0;
      r_fabric_enable <= 1'b0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
    end else begin
      r_sreg          <= w_sreg_nxt;
      r_bit_cnt       <= w_bit_cnt_nxt;
      r_word_bit      <= w_word_bit_nxt;
      r_chain_data    <= w_chain_data_nxt;
      r_chain_enable  <= w_chain_enable_nxt;
      r_fabric_enable <= w_fabric_enable_nxt;
      r_busy          <= w_busy_nxt;
      r_done          <= w_done_nxt;
    end
  end

  assign chain_data    = r_chain_data;
  assign chain_enable  = r_chain_enable;
  assign fabric_enable = r_fabric_enable;
  assign busy          = r_busy;
  assign done          = r_done;

endmodule
